// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the serial pattern detector.
// Imported by the detector top and its counter sub-module.
package seq_det_pkg;

  localparam int unsigned        SEQ_DET_PAT_W_DEF   = 4;
  localparam int unsigned        SEQ_DET_CNT_W_DEF   = 8;
  localparam logic [3:0]         SEQ_DET_PAT_RST_DEF = 4'b0101;

  // Width needed to hold the count of valid history bits, 0..pat_w inclusive.
  function automatic int unsigned seq_det_fill_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Used for the detector's match count.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int unsigned W = SEQ_DET_CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic at_max;

  assign at_max = &q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !at_max) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with a runtime-loadable pattern, overlap/non-overlap
// mode, a registered one-cycle match pulse and a saturating match count.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned       PAT_W   = SEQ_DET_PAT_W_DEF,
  parameter int unsigned       CNT_W   = SEQ_DET_CNT_W_DEF,
  parameter logic [PAT_W-1:0]  PAT_RST = PAT_W'(SEQ_DET_PAT_RST_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seq,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  input  logic             clear,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned           FILL_W   = seq_det_fill_w(PAT_W);
  localparam logic [FILL_W-1:0]     FILL_MAX = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  hist_d;
  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_d;
  logic [PAT_W-1:0]  pat_q;
  logic              ovl_q;
  logic              hit;

  assign hist_shift = {hist[PAT_W-2:0], seq};

  // A hit needs the incoming bit to complete a full window of valid history.
  always_comb begin
    hist_d = hist;
    fill_d = fill;
    hit    = 1'b0;
    if (cfg_load) begin
      fill_d = '0;
    end else if (en) begin
      hist_d = hist_shift;
      hit    = (fill >= FILL_MAX - 1'b1) && (hist_shift == pat_q);
      if (hit && !ovl_q) begin
        fill_d = '0;
      end else if (fill != FILL_MAX) begin
        fill_d = fill + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist  <= '0;
      fill  <= '0;
      pat_q <= PAT_RST;
      ovl_q <= 1'b1;
      out   <= 1'b0;
    end else begin
      hist <= hist_d;
      fill <= fill_d;
      out  <= hit;
      if (cfg_load) begin
        pat_q <= pattern;
        ovl_q <= overlap;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit),
    .clr   (clear),
    .q     (match_cnt)
  );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector: a default instance (8-bit count)
// and a 2-bit-count instance share stimulus; a monitor checks both each cycle.
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       seq;
  logic       cfg_load;
  logic [3:0] pattern;
  logic       overlap;
  logic       clear;
  logic       out_a;
  logic [7:0] cnt_a;
  logic       out_b;
  logic [1:0] cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       exp_out;
    logic [7:0] exp_cnt_a;
    logic [1:0] exp_cnt_b;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] model_a = '0;
  logic [1:0] model_b = '0;
  int step_id = 0;

  always #5 clk = ~clk;

  seq_pattern_detector u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .seq       (seq),
    .cfg_load  (cfg_load),
    .pattern   (pattern),
    .overlap   (overlap),
    .clear     (clear),
    .out       (out_a),
    .match_cnt (cnt_a)
  );

  seq_pattern_detector #(
    .CNT_W (2)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .seq       (seq),
    .cfg_load  (cfg_load),
    .pattern   (pattern),
    .overlap   (overlap),
    .clear     (clear),
    .out       (out_b),
    .match_cnt (cnt_b)
  );

  // Monitor: one expected entry per clocked step, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks += 4;
      if (out_a !== e.exp_out) begin
        n_fail++;
        $display("FAIL step%0d out_a: got %b want %b", e.id, out_a, e.exp_out);
      end
      if (cnt_a !== e.exp_cnt_a) begin
        n_fail++;
        $display("FAIL step%0d cnt_a: got %0d want %0d", e.id, cnt_a, e.exp_cnt_a);
      end
      if (out_b !== e.exp_out) begin
        n_fail++;
        $display("FAIL step%0d out_b: got %b want %b", e.id, out_b, e.exp_out);
      end
      if (cnt_b !== e.exp_cnt_b) begin
        n_fail++;
        $display("FAIL step%0d cnt_b: got %0d want %0d", e.id, cnt_b, e.exp_cnt_b);
      end
    end
  end

  task automatic step(input logic e, input logic s, input logic ld,
                      input logic clr, input logic eo);
    en       = e;
    seq      = s;
    cfg_load = ld;
    clear    = clr;
    @(posedge clk);
    #1;
    if (clr) begin
      model_a = '0;
      model_b = '0;
    end else if (eo) begin
      if (model_a != 8'hff) model_a = model_a + 8'd1;
      if (model_b != 2'b11) model_b = model_b + 2'd1;
    end
    exp_q.push_back('{eo, model_a, model_b, step_id});
    step_id++;
    en       = 1'b0;
    cfg_load = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic load(input logic [3:0] p, input logic ovl);
    pattern = p;
    overlap = ovl;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Feed n bits MSB-first with the hand-computed out value after each edge.
  task automatic feed(input logic [15:0] bits, input logic [15:0] outs, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0, 1'b0, outs[i]);
    end
  endtask

  task automatic direct_zero_check(input string tag);
    n_checks += 2;
    if (out_a !== 1'b0 || out_b !== 1'b0) begin
      n_fail++;
      $display("FAIL %s out: got %b/%b want 0/0", tag, out_a, out_b);
    end
    if (cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
      n_fail++;
      $display("FAIL %s cnt: got %0d/%0d want 0/0", tag, cnt_a, cnt_b);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    seq      = 1'b0;
    cfg_load = 1'b0;
    pattern  = 4'b0000;
    overlap  = 1'b1;
    clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    direct_zero_check("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset pattern 0101, overlap on
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    feed(16'b0101, 16'b0001, 4);

    // Overlap: 01010101 -> hits after bits 4, 6, 8
    load(4'b0101, 1'b1);
    feed(16'b01010101, 16'b00010101, 8);

    // Non-overlap: hits after bits 4, 8
    load(4'b0101, 1'b0);
    feed(16'b01010101, 16'b00010001, 8);

    // New pattern 0110: 0110110 -> hits after bits 4, 7
    load(4'b0110, 1'b1);
    feed(16'b0110110, 16'b0001001, 7);

    // en gaps mid-pattern do not disturb timing in sampled bits
    load(4'b0110, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // cfg_load mid-pattern flushes history
    load(4'b0101, 1'b1);
    feed(16'b010, 16'b000, 3);
    load(4'b0101, 1'b1);
    feed(16'b1, 16'b0, 1);
    feed(16'b0101, 16'b0001, 4);

    // Saturation: 5 matches, 2-bit counter sticks at 3
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    load(4'b0101, 1'b1);
    feed(16'b010101010101, 16'b000101010101, 12);

    // Clear coincident with a match: count 0, out still pulses
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    feed(16'b01, 16'b01, 2);

    // Async reset mid-pattern under a non-default pattern
    load(4'b0110, 1'b1);
    feed(16'b010, 16'b000, 3);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    direct_zero_check("async_rst");
    model_a = '0;
    model_b = '0;
    @(negedge clk);
    rst_n = 1'b1;
    // Pattern back to 0101, partial match lost
    feed(16'b1, 16'b0, 1);
    feed(16'b0101, 16'b0001, 4);

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
